// File: rtl/comm_queue.sv
// Packet FIFO between the command receiver and executor: first-word-fall-through
// output, non-stallable input, with sticky overflow flag and saturating drop counter.
module comm_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_write,
  input  logic [7:0]            in_X,
  input  logic [7:0]            in_Y,
  input  logic [15:0]           in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_X,
  output logic [7:0]            out_Y,
  output logic [15:0]           out_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  input  logic                  overflow_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  overflow_reg;
  logic [7:0]            drop_count_reg;

  logic       pop;
  logic       accept;
  logic       drop;
  logic [7:0] drop_base;

  assign out_valid  = (count_reg != '0);
  assign full       = (count_reg == FULL_COUNT);
  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

  assign pop    = out_valid & out_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign accept = in_write & (~full | pop);
  assign drop   = in_write & ~accept;

  // Clear is applied before the drop increment so a coincident drop counts as one.
  assign drop_base = overflow_clr ? 8'h00 : drop_count_reg;

  always_comb begin
    out_X    = 8'h00;
    out_Y    = 8'h00;
    out_data = 16'h0000;
    if (out_valid) begin
      {out_X, out_Y, out_data} = mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      mem[wr_ptr_reg] <= {in_X, in_Y, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'h00;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + {{DEPTH_LOG2{1'b0}}, accept} - {{DEPTH_LOG2{1'b0}}, pop};
      if (drop) begin
        overflow_reg   <= 1'b1;
        drop_count_reg <= (drop_base == 8'hFF) ? 8'hFF : drop_base + 8'h01;
      end else if (overflow_clr) begin
        overflow_reg   <= 1'b0;
        drop_count_reg <= 8'h00;
      end
    end
  end

endmodule
